// File: rtl/sr_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : sr_step_controller
// Description : Sequences one S/R command at a time into a gate-level SR stage,
//               checks the settled q/t against a golden model, keeps counters.
// Revision    : 1.0 - initial release
// ============================================================================
module sr_step_controller #(
    parameter int   SETTLE_CYCLES = 2,
    parameter int   CNT_W         = 8,
    parameter logic INIT_Q        = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_s,
    input  logic             in_r,
    output logic             sr_s,
    output logic             sr_r,
    output logic             sr_qb,
    input  logic             sr_q,
    input  logic             sr_t,
    output logic             out_valid,
    output logic             out_q,
    output logic             out_qbar,
    output logic             out_forbidden,
    output logic             out_mismatch,
    output logic [CNT_W-1:0] step_count,
    output logic [CNT_W-1:0] err_count
);

    localparam int c_settle_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [c_settle_w-1:0] c_settle_load = c_settle_w'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETTLE  = 2'd1,
        S_CAPTURE = 2'd2,
        S_REPORT  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [c_settle_w-1:0] r_settle_cnt;
    logic                  r_q_state;
    logic                  r_sr_s;
    logic                  r_sr_r;
    logic                  r_out_q;
    logic                  r_out_qbar;
    logic                  r_out_forbidden;
    logic                  r_out_mismatch;
    logic [CNT_W-1:0]      r_step_count;
    logic [CNT_W-1:0]      r_err_count;

    logic                  w_accept;
    logic                  w_q_exp;
    logic                  w_t_exp;

    // Golden SR model evaluated against the held command and stored state
    assign w_q_exp = r_sr_s | (~r_sr_r & r_q_state);
    assign w_t_exp = r_sr_r | ~r_q_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_accept     = 1'b1;
                    w_next_state = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_settle_cnt == '0) begin
                    w_next_state = S_CAPTURE;
                end
            end
            S_CAPTURE: begin
                w_next_state = S_REPORT;
            end
            S_REPORT: begin
                out_valid    = 1'b1;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_settle_cnt    <= '0;
            r_q_state       <= INIT_Q;
            r_sr_s          <= 1'b0;
            r_sr_r          <= 1'b0;
            r_out_q         <= 1'b0;
            r_out_qbar      <= 1'b0;
            r_out_forbidden <= 1'b0;
            r_out_mismatch  <= 1'b0;
            r_step_count    <= '0;
            r_err_count     <= '0;
        end else begin
            if (w_accept) begin
                r_sr_s       <= in_s;
                r_sr_r       <= in_r;
                r_settle_cnt <= c_settle_load;
            end
            if (r_state == S_SETTLE && r_settle_cnt != '0) begin
                r_settle_cnt <= r_settle_cnt - 1'b1;
            end
            // State advances from the model, so a faulty stage cannot corrupt it
            if (r_state == S_CAPTURE) begin
                r_out_q         <= sr_q;
                r_out_qbar      <= sr_t;
                r_out_forbidden <= r_sr_s & r_sr_r;
                r_out_mismatch  <= (sr_q != w_q_exp) | (sr_t != w_t_exp);
                r_q_state       <= w_q_exp;
            end
            if (r_state == S_REPORT) begin
                if (r_step_count != c_cnt_max) begin
                    r_step_count <= r_step_count + 1'b1;
                end
                if (r_out_mismatch && r_err_count != c_cnt_max) begin
                    r_err_count <= r_err_count + 1'b1;
                end
            end
        end
    end

    assign sr_s          = r_sr_s;
    assign sr_r          = r_sr_r;
    assign sr_qb         = r_q_state;
    assign out_q         = r_out_q;
    assign out_qbar      = r_out_qbar;
    assign out_forbidden = r_out_forbidden;
    assign out_mismatch  = r_out_mismatch;
    assign step_count    = r_step_count;
    assign err_count     = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_sr_step_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_sr_step_controller
// Description : Scoreboard bench for sr_step_controller with a behavioural SR
//               stage that can be made to return a wrong q.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_step_controller;

    localparam int   SETTLE = 2;
    localparam int   CW     = 2;
    localparam int   c_max  = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          in_s = 1'b0;
    logic          in_r = 1'b0;
    logic          sr_s;
    logic          sr_r;
    logic          sr_qb;
    logic          sr_q;
    logic          sr_t;
    logic          out_valid;
    logic          out_q;
    logic          out_qbar;
    logic          out_forbidden;
    logic          out_mismatch;
    logic [CW-1:0] step_count;
    logic [CW-1:0] err_count;
    logic          fault_en = 1'b0;

    typedef struct {
        logic q;
        logic t;
        logic forb;
        logic mis;
        logic qb;
        int   sc;
        int   ec;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic mq = 1'b0;
    int   msc = 0;
    int   mec = 0;
    bit   cnt_pend = 0;
    exp_t cnt_exp;

    sr_step_controller #(
        .SETTLE_CYCLES (SETTLE),
        .CNT_W         (CW),
        .INIT_Q        (1'b0)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_s          (in_s),
        .in_r          (in_r),
        .sr_s          (sr_s),
        .sr_r          (sr_r),
        .sr_qb         (sr_qb),
        .sr_q          (sr_q),
        .sr_t          (sr_t),
        .out_valid     (out_valid),
        .out_q         (out_q),
        .out_qbar      (out_qbar),
        .out_forbidden (out_forbidden),
        .out_mismatch  (out_mismatch),
        .step_count    (step_count),
        .err_count     (err_count)
    );

    // SR stage model; fault_en inverts q to emulate a broken stage
    assign sr_q = (sr_s | (~sr_r & sr_qb)) ^ fault_en;
    assign sr_t = sr_r | ~sr_qb;

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cnt_pend) begin
            check_eq("step_count", step_count, cnt_exp.sc);
            check_eq("err_count", err_count, cnt_exp.ec);
            cnt_pend = 0;
        end
        if (out_valid) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_out_valid", 1, 0);
            end else begin
                cnt_exp = sb.pop_front();
                check_eq("out_q", out_q, cnt_exp.q);
                check_eq("out_qbar", out_qbar, cnt_exp.t);
                check_eq("out_forbidden", out_forbidden, cnt_exp.forb);
                check_eq("out_mismatch", out_mismatch, cnt_exp.mis);
                check_eq("sr_qb", sr_qb, cnt_exp.qb);
                cnt_pend = 1;
            end
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        mq  = 1'b0;
        msc = 0;
        mec = 0;
    endtask

    // Called at a negedge; returns at the negedge after the report cycle
    task automatic do_step(input logic s, input logic r, input logic flt);
        exp_t e;
        logic qe;
        logic te;
        int   cyc;
        qe     = s | (~r & mq);
        te     = r | ~mq;
        e.q    = flt ? ~qe : qe;
        e.t    = te;
        e.forb = s & r;
        e.mis  = flt;
        e.qb   = qe;
        mq     = qe;
        if (msc < c_max) msc++;
        if (flt && mec < c_max) mec++;
        e.sc   = msc;
        e.ec   = mec;
        sb.push_back(e);
        fault_en = flt;
        in_s     = s;
        in_r     = r;
        in_valid = 1'b1;
        cyc = 0;
        while (!in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        if (!in_ready) check_eq("accept_timeout", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check_eq("busy_in_ready", in_ready, 0);
        check_eq("sr_s_drive", sr_s, s);
        check_eq("sr_r_drive", sr_r, r);
        cyc = 1;
        while (!out_valid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("latency", cyc, SETTLE + 2);
        @(negedge clk);
        fault_en = 1'b0;
        check_eq("out_valid_pulse", out_valid, 0);
    endtask

    initial begin
        int vcnt;
        logic s;
        logic r;
        logic f;
        @(negedge clk);
        do_reset();
        check_eq("rst_in_ready", in_ready, 1);
        check_eq("rst_sr_qb", sr_qb, 0);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_step_count", step_count, 0);
        check_eq("rst_err_count", err_count, 0);
        check_eq("rst_sr_s", sr_s, 0);
        check_eq("rst_out_q", out_q, 0);

        do_step(1'b1, 1'b0, 1'b0);
        check_eq("hold_sr_s", sr_s, 1);
        do_step(1'b0, 1'b1, 1'b0);
        do_step(1'b1, 1'b1, 1'b0);
        do_step(1'b0, 1'b1, 1'b0);
        do_step(1'b1, 1'b0, 1'b1);
        check_eq("fault_hold_mismatch", out_mismatch, 1);

        for (int i = 0; i < 10; i++) begin
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 2) == 0);
            do_step(s, r, f);
        end
        do_step(1'b0, 1'b0, 1'b1);
        do_step(1'b1, 1'b0, 1'b1);
        do_step(1'b0, 1'b1, 1'b1);
        do_step(1'b1, 1'b0, 1'b0);

        // Abort mid-settle with a stored 1 so the reset restore is visible
        in_s = 1'b0;
        in_r = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mq = 1'b0;
        msc = 0;
        mec = 0;
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) vcnt++;
            @(negedge clk);
        end
        check_eq("abort_no_valid", vcnt, 0);
        check_eq("abort_sr_qb", sr_qb, 0);
        check_eq("abort_in_ready", in_ready, 1);
        check_eq("abort_step_count", step_count, 0);
        check_eq("abort_out_mismatch", out_mismatch, 0);

        do_step(1'b0, 1'b0, 1'b0);
        do_step(1'b1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 1 expected 0");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
